// File: rtl/sofm_nbr_sched_if.sv
// Scheduler control/status bus: BMU start request in, RAM read strobes and adaptation-stage drive out.
interface sofm_nbr_sched_if;
  logic        i_start;
  logic [7:0]  i_win_x;
  logic [7:0]  i_win_y;
  logic [7:0]  i_radius;
  logic [15:0] i_alpha0;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic        o_rd_en;
  logic [7:0]  o_rd_x;
  logic [7:0]  o_rd_y;
  logic [1:0]  o_rd_c;
  logic        o_wr_en;
  logic [1:0]  o_wr_c;
  logic [15:0] o_pos;
  logic [15:0] o_alpha;
  logic        o_update;

  modport master (
    output i_start, i_win_x, i_win_y, i_radius, i_alpha0,
    input  o_busy, o_done, o_err, o_rd_en, o_rd_x, o_rd_y, o_rd_c,
           o_wr_en, o_wr_c, o_pos, o_alpha, o_update
  );

  modport slave (
    input  i_start, i_win_x, i_win_y, i_radius, i_alpha0,
    output o_busy, o_done, o_err, o_rd_en, o_rd_x, o_rd_y, o_rd_c,
           o_wr_en, o_wr_c, o_pos, o_alpha, o_update
  );
endinterface

// File: rtl/sofm_nbr_sched.sv
// SOFM neighbourhood scheduler: one weight read per cycle over the clipped box, write stage one cycle behind.
// Start-to-done 3 + cells*DIM cycles; no backpressure, starts ignored while busy; SCHED_MANHATTAN_EN selects L1 distance.
module sofm_nbr_sched #(
  parameter int MAP_W = 100,
  parameter int MAP_H = 100,
  parameter int DIM   = 3
) (
  input logic            i_clk,
  input logic            i_rst,
  sofm_nbr_sched_if.slave bus
);

  localparam logic [8:0] XMAX  = 9'(MAP_W - 1);
  localparam logic [8:0] YMAX  = 9'(MAP_H - 1);
  localparam logic [8:0] XLIM  = 9'(MAP_W);
  localparam logic [8:0] YLIM  = 9'(MAP_H);
  localparam logic [1:0] CLAST = 2'(DIM - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SCAN, DRAIN, DONE} state_t;

  state_t      state;
  logic [7:0]  wx, wy, r;
  logic [7:0]  x0, x1, y1;
  logic [15:0] a0;

  logic [8:0]  xlo, xhi, ylo, yhi;
  logic [7:0]  bx0, bx1, by0, by1;
  logic [7:0]  dx, dy;
  logic [9:0]  d;
  logic [15:0] alpha_c;
  logic        upd_c;

  // 9-bit differences: bit 8 set means the box edge fell below zero
  always_comb begin
    xlo = {1'b0, wx} - {1'b0, r};
    ylo = {1'b0, wy} - {1'b0, r};
    xhi = {1'b0, wx} + {1'b0, r};
    yhi = {1'b0, wy} + {1'b0, r};
    bx0 = xlo[8] ? 8'd0 : xlo[7:0];
    by0 = ylo[8] ? 8'd0 : ylo[7:0];
    bx1 = (xhi > XMAX) ? XMAX[7:0] : xhi[7:0];
    by1 = (yhi > YMAX) ? YMAX[7:0] : yhi[7:0];
  end

  always_comb begin
    dx = (bus.o_rd_x >= wx) ? bus.o_rd_x - wx : wx - bus.o_rd_x;
    dy = (bus.o_rd_y >= wy) ? bus.o_rd_y - wy : wy - bus.o_rd_y;
`ifdef SCHED_MANHATTAN_EN
    d = {2'b00, dx} + {2'b00, dy};
`else
    d = {2'b00, (dx > dy) ? dx : dy};
`endif
    alpha_c = (d >= 10'd16) ? 16'd0 : (a0 >> d[3:0]);
    upd_c   = (d <= {2'b00, r}) && (alpha_c != 16'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      wx           <= '0;
      wy           <= '0;
      r            <= '0;
      a0           <= '0;
      x0           <= '0;
      x1           <= '0;
      y1           <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
      bus.o_err    <= 1'b0;
      bus.o_rd_en  <= 1'b0;
      bus.o_rd_x   <= '0;
      bus.o_rd_y   <= '0;
      bus.o_rd_c   <= '0;
      bus.o_wr_en  <= 1'b0;
      bus.o_wr_c   <= '0;
      bus.o_pos    <= '0;
      bus.o_alpha  <= '0;
      bus.o_update <= 1'b0;
    end else begin
      // Write stage follows the RAM's one-cycle read latency
      bus.o_wr_en <= bus.o_rd_en;
      if (bus.o_rd_en) begin
        bus.o_pos    <= {bus.o_rd_y, bus.o_rd_x};
        bus.o_wr_c   <= bus.o_rd_c;
        bus.o_alpha  <= alpha_c;
        bus.o_update <= upd_c;
      end else begin
        bus.o_pos    <= '0;
        bus.o_wr_c   <= '0;
        bus.o_alpha  <= '0;
        bus.o_update <= 1'b0;
      end
      bus.o_done <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.i_start) begin
            wx         <= bus.i_win_x;
            wy         <= bus.i_win_y;
            r          <= bus.i_radius;
            a0         <= bus.i_alpha0;
            bus.o_err  <= 1'b0;
            bus.o_busy <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          if ({1'b0, wx} >= XLIM || {1'b0, wy} >= YLIM) begin
            bus.o_err  <= 1'b1;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b1;
            state      <= DONE;
          end else begin
            x0          <= bx0;
            x1          <= bx1;
            y1          <= by1;
            bus.o_rd_x  <= bx0;
            bus.o_rd_y  <= by0;
            bus.o_rd_c  <= 2'd0;
            bus.o_rd_en <= 1'b1;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (bus.o_rd_c != CLAST) begin
            bus.o_rd_c <= bus.o_rd_c + 2'd1;
          end else if (bus.o_rd_x != x1) begin
            bus.o_rd_c <= 2'd0;
            bus.o_rd_x <= bus.o_rd_x + 8'd1;
          end else if (bus.o_rd_y != y1) begin
            bus.o_rd_c <= 2'd0;
            bus.o_rd_x <= x0;
            bus.o_rd_y <= bus.o_rd_y + 8'd1;
          end else begin
            bus.o_rd_en <= 1'b0;
            bus.o_rd_c  <= '0;
            bus.o_rd_x  <= '0;
            bus.o_rd_y  <= '0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          bus.o_busy <= 1'b0;
          bus.o_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sofm_nbr_sched.sv
// Randomized bench for sofm_nbr_sched against a box-walk reference model built from queues.
module tb_sofm_nbr_sched;
  localparam int MAP_W = 100;
  localparam int MAP_H = 100;
  localparam int DIM   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sofm_nbr_sched_if bus ();

  sofm_nbr_sched #(.MAP_W(MAP_W), .MAP_H(MAP_H), .DIM(DIM)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int c;
    int alpha;
    int upd;
  } cell_t;

  cell_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Expected write list in scan order, plus pass length and error flag
  task automatic build(input int wx, input int wy, input int r, input int a0,
                       output int n, output bit err, output int nupd);
    int xs, xe, ys, ye, d, al, up;
    q.delete();
    n = 0;
    nupd = 0;
    err = (wx >= MAP_W) || (wy >= MAP_H);
    if (!err) begin
      xs = (wx - r < 0) ? 0 : wx - r;
      ys = (wy - r < 0) ? 0 : wy - r;
      xe = (wx + r > MAP_W - 1) ? MAP_W - 1 : wx + r;
      ye = (wy + r > MAP_H - 1) ? MAP_H - 1 : wy + r;
      for (int y = ys; y <= ye; y++)
        for (int x = xs; x <= xe; x++)
          for (int c = 0; c < DIM; c++) begin
`ifdef SCHED_MANHATTAN_EN
            d = absd(x, wx) + absd(y, wy);
`else
            d = (absd(x, wx) > absd(y, wy)) ? absd(x, wx) : absd(y, wy);
`endif
            al = (d >= 16) ? 0 : (a0 >> d);
            up = (d <= r && al != 0) ? 1 : 0;
            nupd += up;
            q.push_back('{x: x, y: y, c: c, alpha: al, upd: up});
          end
      n = q.size();
    end
  endtask

  task automatic scramble();
    bus.i_win_x  = 8'($urandom);
    bus.i_win_y  = 8'($urandom);
    bus.i_radius = 8'($urandom);
    bus.i_alpha0 = 16'($urandom);
  endtask

  task automatic run_pass(input int wx, input int wy, input int r, input int a0, input bit poke);
    int n, nupd, done_t, t, rd_i, wr_i, seen_upd;
    bit err;
    build(wx, wy, r, a0, n, err, nupd);
    done_t = err ? 2 : n + 3;
    t = 0;
    rd_i = 0;
    wr_i = 0;
    seen_upd = 0;
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_win_x  = 8'(wx);
    bus.i_win_y  = 8'(wy);
    bus.i_radius = 8'(r);
    bus.i_alpha0 = 16'(a0);
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    scramble();
    while (t <= done_t) begin
      @(negedge clk);
      t++;
      if (poke && t == 4) begin
        scramble();
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      chk("busy",  bus.o_busy,  t < done_t);
      chk("done",  bus.o_done,  t == done_t);
      chk("err",   bus.o_err,   err && t >= 2);
      chk("rd_en", bus.o_rd_en, !err && t >= 2 && t <= n + 1);
      chk("wr_en", bus.o_wr_en, !err && t >= 3 && t <= n + 2);
      if (bus.o_rd_en) begin
        if (rd_i < n) begin
          chk("rd_x", bus.o_rd_x, q[rd_i].x);
          chk("rd_y", bus.o_rd_y, q[rd_i].y);
          chk("rd_c", bus.o_rd_c, q[rd_i].c);
        end
        rd_i++;
      end
      if (bus.o_wr_en) begin
        if (wr_i < n) begin
          chk("pos",    bus.o_pos,    q[wr_i].y * 256 + q[wr_i].x);
          chk("wr_c",   bus.o_wr_c,   q[wr_i].c);
          chk("alpha",  bus.o_alpha,  q[wr_i].alpha);
          chk("update", bus.o_update, q[wr_i].upd);
        end
        seen_upd += int'(bus.o_update);
        wr_i++;
      end
    end
    chk("n_wr",  wr_i, n);
    chk("n_upd", seen_upd, nupd);
  endtask

  task automatic run_abort();
    @(negedge clk);
    bus.i_start  = 1'b1;
    bus.i_win_x  = 8'd50;
    bus.i_win_y  = 8'd50;
    bus.i_radius = 8'd3;
    bus.i_alpha0 = 16'h8000;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("abort_scan", bus.o_rd_en, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_outs", {bus.o_busy, bus.o_done, bus.o_err, bus.o_rd_en, bus.o_rd_x, bus.o_rd_y,
                       bus.o_rd_c, bus.o_wr_en, bus.o_wr_c, bus.o_pos, bus.o_alpha, bus.o_update}, 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_quiet", {bus.o_busy, bus.o_done, bus.o_rd_en, bus.o_wr_en}, 64'd0);
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.i_start  = 1'b0;
    bus.i_win_x  = '0;
    bus.i_win_y  = '0;
    bus.i_radius = '0;
    bus.i_alpha0 = '0;
    #12;
    chk("reset_outs", {bus.o_busy, bus.o_done, bus.o_err, bus.o_rd_en, bus.o_rd_x, bus.o_rd_y,
                       bus.o_rd_c, bus.o_wr_en, bus.o_wr_c, bus.o_pos, bus.o_alpha, bus.o_update}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_pass(50, 50, 1, 16'h8000, 1'b0);
    run_pass(0, 0, 2, 16'h8000, 1'b0);
    run_pass(120, 5, 1, 16'h8000, 1'b0);
    run_pass(50, 50, 20, 16'hFFFF, 1'b0);
    run_pass(99, 99, 3, 16'h1234, 1'b1);
    run_pass(7, 93, 0, 16'hABCD, 1'b1);
    run_abort();
    run_pass(50, 50, 1, 16'h8000, 1'b0);

    for (int i = 0; i < 12; i++)
      run_pass(int'($urandom_range(0, 109)), int'($urandom_range(0, 109)),
               int'($urandom_range(0, 5)), int'($urandom_range(0, 65535)), i[0]);

    run_pass(50, 50, 255, int'($urandom_range(1, 65535)), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
